sd_adc_fir_filter: RTL

- Post-decimation compensation/low-pass FIR that consumes the decimated samples from sigma_delta_adc (adc_output/adc_valid) and produces filtered PCM samples at the same rate.
- Samples arrive once per BOSR clocks, so a single time-multiplexed multiplier is enough: one MAC per clock over a circular sample buffer.
- Sits between sigma_delta_adc and any audio sink or serializer.

---
 rtl/sd_filter_pkg.sv | 37 +++
 rtl/sd_fir_coef_rom.sv | 17 +
 rtl/sd_adc_fir_filter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sd_filter_pkg.sv
// Shared constants, types and coefficient table for the post-decimation FIR.
// The coefficients are a symmetric 52-tap low-pass in Q1.17 with unity DC gain.
package sd_filter_pkg;

  localparam int COEF_W    = 18;
  localparam int COEF_FRAC = 17;
  localparam int NUM_COEFS = 52;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_ROUND
  } fir_state_t;

  // Mirror-symmetric about taps 25/26; the taps sum to exactly 2^17.
  localparam coef_t FIR_COEFS [0:NUM_COEFS-1] = '{
    -18'sd3,     18'sd12,    -18'sd15,    -18'sd10,     18'sd50,
    -18'sd40,   -18'sd40,     18'sd130,   -18'sd60,    -18'sd150,
     18'sd300,  -18'sd50,    -18'sd400,    18'sd600,    18'sd50,
    -18'sd900,   18'sd1100,   18'sd400,   -18'sd2000,   18'sd1800,
     18'sd1500, -18'sd4500,   18'sd3000,   18'sd8000,  -18'sd25410,
     18'sd82172, 18'sd82172, -18'sd25410,  18'sd8000,   18'sd3000,
    -18'sd4500,  18'sd1500,   18'sd1800,  -18'sd2000,   18'sd400,
     18'sd1100, -18'sd900,    18'sd50,     18'sd600,   -18'sd400,
    -18'sd50,    18'sd300,   -18'sd150,   -18'sd60,     18'sd130,
    -18'sd40,   -18'sd40,     18'sd50,    -18'sd10,    -18'sd15,
     18'sd12,   -18'sd3
  };

  function automatic int acc_width(input int wdth, input int coef_w, input int taps);
    return wdth + 1 + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/sd_fir_coef_rom.sv
// Synchronous-read coefficient ROM with one cycle of read latency.
module sd_fir_coef_rom
  import sd_filter_pkg::*;
#(
  parameter int TAPS = 52,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output coef_t         coef
);

  always_ff @(posedge clk) begin
    coef <= FIR_COEFS[addr];
  end

endmodule

// File: rtl/sd_adc_fir_filter.sv
// Time-multiplexed FIR behind the sigma-delta decimator: one MAC per clock over a
// circular sample buffer, then round-half-up and saturate to an unsigned output.
module sd_adc_fir_filter #(
  parameter int WDTH      = 16,
  parameter int OUT_W     = 16,
  parameter int TAPS      = 52,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WDTH-1:0]  in_sample,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_sample,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);
  import sd_filter_pkg::*;

  localparam int PTR_W = $clog2(TAPS);
  localparam int K_W   = $clog2(TAPS + 1);
  localparam int P_W   = WDTH + 1 + COEF_W;
  localparam int ACC_W = acc_width(WDTH, COEF_W, TAPS);

  localparam logic [PTR_W-1:0]        LAST_PTR   = PTR_W'(TAPS - 1);
  localparam logic [K_W-1:0]          TAPS_K     = K_W'(TAPS);
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX    = (ACC_W'(1) << OUT_W) - ACC_W'(1);

  fir_state_t state_q, state_d;

  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [K_W-1:0]          k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    mac_vld_q;
  logic [WDTH-1:0]         smp_q;
  logic signed [COEF_W-1:0] coef_q;

  logic [WDTH-1:0]         sbuf [TAPS];
  logic                    buf_we;
  logic [WDTH-1:0]         buf_wdata;
  logic                    issue;
  logic [PTR_W-1:0]        rom_addr;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] rounded;
  logic [OUT_W-1:0]        sat_val;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST_PTR : p - 1'b1;
  endfunction

  sd_fir_coef_rom #(
    .TAPS (TAPS),
    .AW   (PTR_W)
  ) u_coef_rom (
    .clk  (clk),
    .addr (rom_addr),
    .coef (coef_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  // CLEAR reuses the write pointer as its sweep address, so it wraps back to 0 on exit.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    buf_we    = 1'b0;
    buf_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        buf_we = 1'b1;
        if (wr_ptr_q == LAST_PTR) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (in_valid) begin
          buf_we    = 1'b1;
          buf_wdata = in_sample;
          state_d   = ST_MAC;
        end
      end
      ST_MAC: begin
        if (k_q == TAPS_K) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_comb begin
    issue    = (state_q == ST_MAC) && (k_q != TAPS_K);
    rom_addr = issue ? PTR_W'(k_q) : '0;
    prod     = $signed({1'b0, smp_q}) * coef_q;
    rounded  = (acc_q + ROUND_HALF) >>> COEF_FRAC;
    if (rounded[ACC_W-1])      sat_val = '0;
    else if (rounded > OUT_MAX) sat_val = '1;
    else                        sat_val = rounded[OUT_W-1:0];
  end

  // The buffer read is registered alongside the ROM so sample and coefficient line up.
  always_ff @(posedge clk) begin
    if (buf_we && !rst) sbuf[wr_ptr_q] <= buf_wdata;
    smp_q <= sbuf[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      mac_vld_q  <= 1'b0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      mac_vld_q <= issue;
      if (in_valid && busy) overrun <= 1'b1;
      if (mac_vld_q) acc_q <= acc_q + ACC_W'(prod);
      case (state_q)
        ST_CLEAR: begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        ST_IDLE: begin
          if (in_valid) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
            rd_ptr_q <= wr_ptr_q;
            k_q      <= '0;
            acc_q    <= '0;
          end
        end
        ST_MAC: begin
          if (issue) begin
            rd_ptr_q <= ptr_dec(rd_ptr_q);
            k_q      <= k_q + 1'b1;
          end
        end
        ST_ROUND: begin
          out_sample <= sat_val;
          out_valid  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
